// File: rtl/block_mac_2x2.sv
// Purpose: 2x2 block multiply-accumulate, C += A*B, one shared multiplier, accumulators persist across calls.
// Latency: 9 cycles from start sample in IDLE to the one-cycle done pulse; one op per 10 cycles.
// Backpressure: none; start is a level request, ignored while busy, and a held start yields one op.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start, acc_clr  level request / accumulator clear, both sampled only in IDLE
//   a_*, b_*        A and B block operands, latched on the accepted start
//   c_*             accumulator contents (registered)
//   busy, done      busy in CALC/DONE/HOLD; done pulses for one cycle after the 8th product
module block_mac_2x2 #(
  parameter int data_w = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_clr,
  input  logic [data_w-1:0] a_11,
  input  logic [data_w-1:0] a_12,
  input  logic [data_w-1:0] a_21,
  input  logic [data_w-1:0] a_22,
  input  logic [data_w-1:0] b_11,
  input  logic [data_w-1:0] b_12,
  input  logic [data_w-1:0] b_21,
  input  logic [data_w-1:0] b_22,
  output logic [data_w-1:0] c_11,
  output logic [data_w-1:0] c_12,
  output logic [data_w-1:0] c_21,
  output logic [data_w-1:0] c_22,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Latched operand block, captured once so later input changes cannot disturb the op.
  typedef struct packed {
    logic [data_w-1:0] a_11;
    logic [data_w-1:0] a_12;
    logic [data_w-1:0] a_21;
    logic [data_w-1:0] a_22;
    logic [data_w-1:0] b_11;
    logic [data_w-1:0] b_12;
    logic [data_w-1:0] b_21;
    logic [data_w-1:0] b_22;
  } blk_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        s;
  blk_t              ops;
  logic [data_w-1:0] acc [4];
  logic [data_w-1:0] mul_a;
  logic [data_w-1:0] mul_b;
  logic [data_w-1:0] prod;
  logic [1:0]        acc_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (s == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = start ? HOLD : IDLE;
      HOLD:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      HOLD:    busy = 1'b1;
      default: ;
    endcase
  end

  // Step s walks c11,c11,c12,c12,c21,c21,c22,c22: s[2] picks the A row,
  // s[1] the B column, s[0] the inner index k.
  always_comb begin
    mul_a = ops.a_11;
    mul_b = ops.b_11;
    case ({s[2], s[0]})
      2'b00:   mul_a = ops.a_11;
      2'b01:   mul_a = ops.a_12;
      2'b10:   mul_a = ops.a_21;
      default: mul_a = ops.a_22;
    endcase
    case ({s[0], s[1]})
      2'b00:   mul_b = ops.b_11;
      2'b01:   mul_b = ops.b_12;
      2'b10:   mul_b = ops.b_21;
      default: mul_b = ops.b_22;
    endcase
  end

  // Low data_w bits of the product; the accumulate wraps modulo 2^data_w.
  assign prod    = mul_a * mul_b;
  assign acc_idx = s[2:1];

  // Datapath: operand latch, accumulators and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= 3'd0;
      ops <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          s <= 3'd0;
          if (start) begin
            ops.a_11 <= a_11;
            ops.a_12 <= a_12;
            ops.a_21 <= a_21;
            ops.a_22 <= a_22;
            ops.b_11 <= b_11;
            ops.b_12 <= b_12;
            ops.b_21 <= b_21;
            ops.b_22 <= b_22;
          end
          if (acc_clr) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
          end
        end
        CALC: begin
          acc[acc_idx] <= acc[acc_idx] + prod;
          s            <= s + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign c_11 = acc[0];
  assign c_12 = acc[1];
  assign c_21 = acc[2];
  assign c_22 = acc[3];

endmodule

// File: tb/tb_block_mac_2x2.sv
// Bench for block_mac_2x2: matrix-level model plus directed vectors with literal results.
module tb_block_mac_2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic        acc_clr = 1'b0;
  logic [31:0] a_11 = '0, a_12 = '0, a_21 = '0, a_22 = '0;
  logic [31:0] b_11 = '0, b_12 = '0, b_21 = '0, b_22 = '0;
  logic [31:0] c_11, c_12, c_21, c_22;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  block_mac_2x2 #(.data_w(32)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_clr(acc_clr),
    .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
    .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
    .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the whole op result is computed as a matrix product when the
  // request is accepted; timing is tracked as cycles elapsed since then.
  logic [31:0] m_c11 = '0, m_c12 = '0, m_c21 = '0, m_c22 = '0;
  int          m_age = 0;   // 0 = not computing, 1..8 = calc cycles, 9 = done cycle
  bit          m_hold = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_c11 = '0; m_c12 = '0; m_c21 = '0; m_c22 = '0;
      m_age = 0; m_hold = 1'b0;
    end else if (m_age == 0 && !m_hold) begin
      if (acc_clr) begin
        m_c11 = '0; m_c12 = '0; m_c21 = '0; m_c22 = '0;
      end
      if (start) begin
        m_c11 = m_c11 + a_11 * b_11 + a_12 * b_21;
        m_c12 = m_c12 + a_11 * b_12 + a_12 * b_22;
        m_c21 = m_c21 + a_21 * b_11 + a_22 * b_21;
        m_c22 = m_c22 + a_21 * b_12 + a_22 * b_22;
        m_age = 1;
      end
    end else if (m_age >= 1 && m_age <= 8) begin
      m_age++;
    end else if (m_age == 9) begin
      m_age  = 0;
      m_hold = start;
    end else if (m_hold && !start) begin
      m_hold = 1'b0;
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  initial begin
    logic exp_busy, exp_done;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_busy = (m_age != 0) || m_hold;
      exp_done = (m_age == 9);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done || !exp_busy) begin
        chk("c_11", c_11, m_c11);
        chk("c_12", c_12, m_c12);
        chk("c_21", c_21, m_c21);
        chk("c_22", c_22, m_c22);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input logic [31:0] x11, x12, x21, x22, y11, y12, y21, y22);
    a_11 = x11; a_12 = x12; a_21 = x21; a_22 = x22;
    b_11 = y11; b_12 = y12; b_21 = y21; b_22 = y22;
  endtask

  task automatic chk_c(input string tag, input logic [31:0] e11, e12, e21, e22);
    chk({tag, ".c_11"}, c_11, e11);
    chk({tag, ".c_12"}, c_12, e12);
    chk({tag, ".c_21"}, c_21, e21);
    chk({tag, ".c_22"}, c_22, e22);
  endtask

  // One-shot op; returns on the done cycle (or after a bounded wait).
  task automatic run_op(input string tag, input logic clr, input bit scramble);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    start = 1'b1;
    acc_clr = clr;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (i == 1) begin
        start = 1'b0;
        acc_clr = 1'b0;
      end
      if (done) begin
        found = 1'b1;
        n = i;
      end else if (scramble) begin
        set_ops($urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom);
      end
    end
    chk({tag, ".latency"}, n, 32'd9);
  endtask

  initial begin
    int ndone, first_done;

    // Reset with start high: nothing may move.
    tick();
    tick();
    chk_c("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("reset.busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();

    // Basic multiply with start held for 23 cycles.
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    start = 1'b1;
    acc_clr = 1'b1;
    ndone = 0;
    first_done = 0;
    for (int i = 1; i <= 23; i++) begin
      tick();
      acc_clr = 1'b0;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = i;
        chk_c("basic", 32'd19, 32'd22, 32'd43, 32'd50);
      end
    end
    chk("basic.done_count", ndone, 32'd1);
    chk("basic.latency", first_done, 32'd9);
    chk("hold.busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    tick();
    chk("hold.busy_drop", {31'b0, busy}, 32'd0);

    // Accumulate identity * ones on top of the basic result.
    set_ops(1, 0, 0, 1, 1, 1, 1, 1);
    run_op("accum", 1'b0, 1'b0);
    chk_c("accum", 32'd20, 32'd23, 32'd44, 32'd51);
    tick();

    // Wrap-around cases.
    set_ops(32'hFFFF_FFFF, 0, 0, 0, 2, 0, 0, 0);
    run_op("wrap1", 1'b1, 1'b0);
    chk_c("wrap1", 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0);
    tick();
    set_ops(32'h0001_0000, 0, 0, 0, 32'h0001_0000, 0, 0, 0);
    run_op("wrap2", 1'b1, 1'b0);
    chk_c("wrap2", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // Operand isolation: inputs scrambled through the calc cycles.
    set_ops(2, 3, 4, 5, 6, 7, 8, 9);
    run_op("isol", 1'b1, 1'b0 | 1'b1);
    chk_c("isol", 32'd36, 32'd41, 32'd64, 32'd73);
    tick();

    // Abort via reset in cycle 4 of CALC.
    set_ops(1, 1, 1, 1, 1, 1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("abort.no_done", {31'b0, done}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort.no_done_after", {31'b0, done}, 32'd0);
    end
    chk_c("abort", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("abort.busy", {31'b0, busy}, 32'd0);

    // Next start accepted after abort; accumulators were zeroed by reset.
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    run_op("restart", 1'b0, 1'b0);
    chk_c("restart", 32'd19, 32'd22, 32'd43, 32'd50);
    tick();

    // acc_clr alone in IDLE.
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk_c("clr", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("clr.busy", {31'b0, busy}, 32'd0);
    tick();
    chk("clr.busy_after", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
